// File: rtl/aes128_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_round_ctrl_pkg
//  Brief    : Shared types, round constants and GF(2^8) helpers for the
//             iterative AES-128 encryption sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package aes128_round_ctrl_pkg;

    localparam int NR_AES128 = 10;

    typedef logic [127:0] aes_blk_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_ctrl_st_t;

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] r;
        case (rnd)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse computed as a^254 by square-and-multiply, then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_round_ctrl_key_step.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_step
//  Brief    : Combinational AES-128 key expansion step (one round key forward).
//  Revision : 1.0 - initial release
// ============================================================================
module aes_key_step
    import aes128_round_ctrl_pkg::*;
(
    input  logic [127:0] i_rkey,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_rkey
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_rot;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign {w_w0, w_w1, w_w2, w_w3} = i_rkey;

    assign w_rot  = {w_w3[23:0], w_w3[31:24]};
    assign w_temp = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                     sbox(w_rot[15:8]),  sbox(w_rot[7:0])} ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_rkey = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes128_round_ctrl
//  Brief    : Iterative AES-128 encryptor, one round per clock, valid/ready I/O.
//  Revision : 1.0 - initial release
// ============================================================================
module aes128_round_ctrl
    import aes128_round_ctrl_pkg::*;
#(
    parameter int NR            = 10,
    parameter bit CLEAR_ON_DONE = 1'b1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_text,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_text,
    output logic         busy,
    output logic [3:0]   round_o
);

    localparam logic [3:0] NR_LAST = 4'(NR);

    generate
        if (NR != NR_AES128) begin : g_bad_nr
            $error("aes128_round_ctrl: NR must be 10 for AES-128");
        end
    endgenerate

    aes_ctrl_st_t st_q, st_d;
    aes_blk_t     state_q, state_d;
    aes_blk_t     rkey_q, rkey_d;
    aes_blk_t     out_text_q, out_text_d;
    logic [3:0]   round_q, round_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic         busy_q, busy_d;

    aes_blk_t     w_next_rkey;
    aes_blk_t     w_sub;
    aes_blk_t     w_shift;
    aes_blk_t     w_mix;
    aes_blk_t     w_round_out;
    logic         w_final;

    aes_key_step u_key_step (
        .i_rkey (rkey_q),
        .i_rcon (rcon(round_q)),
        .o_rkey (w_next_rkey)
    );

    // Byte i lives at [127-8i -: 8]; byte (row r, col c) is index 4c+r.
    always_comb begin
        w_sub = '0;
        for (int i = 0; i < 16; i++) begin
            w_sub[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
        end
    end

    always_comb begin
        w_shift = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_shift[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
    end

    always_comb begin
        w_mix = '0;
        for (int c = 0; c < 4; c++) begin
            w_mix[127-32*c -: 32] = mix_column(w_shift[127-32*c -: 32]);
        end
    end

    assign w_final     = (round_q == NR_LAST);
    assign w_round_out = (w_final ? w_shift : w_mix) ^ w_next_rkey;

    always_comb begin
        st_d       = st_q;
        state_d    = state_q;
        rkey_d     = rkey_q;
        out_text_d = out_text_q;
        round_d    = round_q;
        case (st_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = in_text ^ in_key;
                    rkey_d  = in_key;
                    round_d = 4'd1;
                    st_d    = RUN;
                end
            end
            RUN: begin
                state_d = w_round_out;
                rkey_d  = w_next_rkey;
                if (w_final) begin
                    out_text_d = w_round_out;
                    st_d       = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            DONE: begin
                // No acceptance here: the earliest re-accept is the next cycle from IDLE.
                if (out_ready) begin
                    st_d    = IDLE;
                    round_d = 4'd0;
                    if (CLEAR_ON_DONE) begin
                        state_d    = '0;
                        rkey_d     = '0;
                        out_text_d = '0;
                    end
                end
            end
            default: begin
                st_d    = IDLE;
                round_d = 4'd0;
            end
        endcase
        in_ready_d  = (st_d == IDLE);
        out_valid_d = (st_d == DONE);
        busy_d      = (st_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            out_text_q  <= '0;
            round_q     <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            rkey_q      <= rkey_d;
            out_text_q  <= out_text_d;
            round_q     <= round_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_text  = out_text_q;
    assign busy      = busy_q;
    assign round_o   = round_q;

endmodule
`default_nettype wire
